bus_peripheral: RTL and testbench
=================================

# bus_peripheral

Memory-mapped peripheral block on the CPU data bus, sitting alongside the data memory and selected by addresses in the 0x4000_0000 page. It holds a reloadable interrupt timer, an LED register, a 7-segment digit register, and a free-running system tick counter. The CPU reaches it with the same load/store bus that drives the data memory. It raises an interrupt request to the CPU core.

## Interface
Parameters:
- `BASE`, 32'h4000_0000, base address of the register page.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `Address`  in  32  byte address from the CPU; word-aligned, bits [1:0] ignored.
- `Write_data`  in  32  store data.
- `MemRead`  in  1  load strobe.
- `MemWrite`  in  1  store strobe.
- `Read_data`  out  32  load data; combinational.
- `leds`  out  8  LED register.
- `digits`  out  12  [11:8] active-low anode select, [7:0] segment pattern.
- `irqout`  out  1  timer interrupt request, level.

## Operation
Register map, word offsets from `BASE`:
- 0x00 `TH`: 32-bit reload value, R/W.
- 0x04 `TL`: 32-bit counter, R/W.
- 0x08 `TCON`: bits [2:0] R/W; bits [31:3] read 0.
  - bit 0 = enable.
  - bit 1 = irq enable.
  - bit 2 = irq status.
- 0x0C `LED`: bits [7:0] R/W; read zero-extended.
- 0x10 `DIGI`: bits [11:0] R/W; read zero-extended.
- 0x14 `SYSTICK`: 32-bit, read-only; writes are ignored.

Address decode and reads:
- Hit = `Address[31:5] == BASE[31:5]` and `Address[4:2]` ≤ 5.
- Offsets 0x18 and 0x1C, and any address outside the page: reads return 0, writes are ignored.
- `Read_data` = `MemRead && hit` ? selected register : 32'h0.

Timer:
- When `TCON[0]`=1, `TL` increments each cycle.
- When `TL` == 32'hFFFF_FFFF and the timer is enabled, the next value of `TL` is `TH` (reload), not 0.
- On that reload, if `TCON[1]`=1, `TCON[2]` is set.
- When `TCON[0]`=0, `TL` holds its value.

Interrupt:
- `irqout` = `TCON[1] & TCON[2]`.
- Software clears the interrupt by writing `TCON` with bit 2 = 0.

SYSTICK:
- Increments every cycle regardless of `TCON`.
- Wraps from 32'hFFFF_FFFF to 0.

Outputs:
- `leds` and `digits` drive the `LED` and `DIGI` registers directly.

## Timing
- Reset (sampled at `clk` edge): `TH`, `TL`, `TCON`, `LED`, `DIGI` and `SYSTICK` all become 0. Therefore `leds`=0, `digits`=0, `irqout`=0.
- `reset` has priority over all writes and counting in the same cycle.
- Reset mid-count aborts the count; no interrupt is set.
- Writes take effect at the `clk` edge where `MemWrite`=1. The new value is visible to reads in the following cycle.
- Write to `TL` in the same cycle as an increment or reload: the written value wins.
- Write to `TCON` in the same cycle as an overflow that sets status: the new `TCON[2]` = `Write_data[2] | (Write_data[1] & overflow)`.
  - Enable and irq enable take their written values.
  - An overflow on the exact clearing cycle is therefore not lost.
- Overflow-to-`irqout` latency: `irqout` rises in the cycle after the edge where `TL` reloads.
- `MemRead` and `MemWrite` both high: the write happens at the edge; `Read_data` meanwhile shows the pre-write value.

## Structure
Shared package:
- Register offset constants: `OFS_TH`, `OFS_TL`, `OFS_TCON`, `OFS_LED`, `OFS_DIGI`, `OFS_SYSTICK`.
- `TCON` bit indices: `TCON_EN`, `TCON_IE`, `TCON_IS`.
- The same constants are reused by the top-level bus mux that steers loads between data memory and this block.

Sub-module `periph_timer`:
- Contains `TH`, `TL`, `TCON`, the reload logic and `irqout`.
- Exposes write-enable-per-register inputs and register-value outputs.

`bus_peripheral` itself:
- Holds the address decoder, `LED`, `DIGI`, `SYSTICK` and the read mux.

## Test plan
- Reset then read every offset:
  - All reads return 0; `irqout`=0.
  - A read at `BASE`+0x18 returns 0.
  - A read at 0x1000_0000 returns 0.
- Write `TH`=32'hFFFF_FFFC, `TL`=32'hFFFF_FFFE, `TCON`=3:
  - `TL` steps FFFF_FFFE → FFFF_FFFF → FFFF_FFFC.
  - `TCON` reads 7 after the reload.
  - `irqout`=1 one cycle after the reload.
- With `irqout` high, write `TCON`=3:
  - `irqout` falls next cycle.
  - The next reload (4 cycles later) raises it again.
- Write `TCON`=3 on the exact overflow cycle:
  - `TCON` reads 7; `irqout` stays/goes 1.
- Write `LED`=8'hA5 and `DIGI`=12'hE3F:
  - `leds`=A5 and `digits`=E3F from the next cycle.
  - Reads return 32'h0000_00A5 and 32'h0000_0E3F.
- Read `SYSTICK` at cycles t and t+10: the difference is 10.
- Write `SYSTICK`=5: ignored; counting continues.
- Assert `reset` while the timer is running with `TL` near overflow:
  - All registers read 0 next cycle; no `irqout` pulse.

Source files
------------

// File: rtl/bus_peripheral_pkg.sv
// Shared register map and TCON bit layout for the peripheral page.
// The CPU-side bus mux reuses these offsets to steer loads between
// data memory and this block.
package bus_peripheral_pkg;

  // Byte offsets of each register inside the 32-byte page.
  localparam logic [4:0] OFS_TH      = 5'h00;
  localparam logic [4:0] OFS_TL      = 5'h04;
  localparam logic [4:0] OFS_TCON    = 5'h08;
  localparam logic [4:0] OFS_LED     = 5'h0C;
  localparam logic [4:0] OFS_DIGI    = 5'h10;
  localparam logic [4:0] OFS_SYSTICK = 5'h14;

  // Highest implemented word index; words 6 and 7 are holes.
  localparam logic [2:0] LAST_WORD = 3'd5;

  // TCON bit indices.
  localparam int TCON_EN = 0;  // timer enable
  localparam int TCON_IE = 1;  // interrupt enable
  localparam int TCON_IS = 2;  // interrupt status (sticky until cleared by software)

endpackage

// File: rtl/periph_timer.sv
// Reloadable interrupt timer: TH (reload), TL (counter), TCON (control/status).
// TL counts up while enabled; on reaching all-ones it reloads from TH and,
// if interrupts are enabled, latches the status bit that drives irqout.
module periph_timer
  import bus_peripheral_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        th_we,
  input  logic        tl_we,
  input  logic        tcon_we,
  input  logic [31:0] wdata,
  output logic [31:0] th,
  output logic [31:0] tl,
  output logic [2:0]  tcon,
  output logic        irqout
);

  logic [31:0] th_q, th_d;
  logic [31:0] tl_q, tl_d;
  logic [2:0]  tcon_q, tcon_d;
  logic        overflow;

  // Overflow is the reload event: enabled counter sitting at all-ones.
  assign overflow = tcon_q[TCON_EN] && (tl_q == 32'hFFFF_FFFF);

  // Next-state for the three timer registers; a bus write always wins over
  // counting, but a TCON write still folds in a same-cycle overflow so a
  // status clear never swallows an interrupt.
  always_comb begin
    th_d   = th_q;
    tl_d   = tl_q;
    tcon_d = tcon_q;

    if (th_we) th_d = wdata;

    if (tl_we)         tl_d = wdata;
    else if (overflow) tl_d = th_q;
    else if (tcon_q[TCON_EN]) tl_d = tl_q + 32'd1;

    if (tcon_we) begin
      tcon_d[TCON_EN] = wdata[TCON_EN];
      tcon_d[TCON_IE] = wdata[TCON_IE];
      tcon_d[TCON_IS] = wdata[TCON_IS] | (wdata[TCON_IE] & overflow);
    end else if (overflow && tcon_q[TCON_IE]) begin
      tcon_d[TCON_IS] = 1'b1;
    end
  end

  // Register update with synchronous reset taking priority.
  always_ff @(posedge clk) begin
    if (reset) begin
      th_q   <= '0;
      tl_q   <= '0;
      tcon_q <= '0;
    end else begin
      th_q   <= th_d;
      tl_q   <= tl_d;
      tcon_q <= tcon_d;
    end
  end

  assign th     = th_q;
  assign tl     = tl_q;
  assign tcon   = tcon_q;
  assign irqout = tcon_q[TCON_IE] & tcon_q[TCON_IS];

endmodule

// File: rtl/bus_peripheral.sv
// Memory-mapped peripheral page: address decode, LED and 7-segment digit
// registers, free-running SYSTICK, the load mux, and the timer sub-block.
//
// Bus protocol: there is no valid/ready handshake. MemRead and MemWrite are
// per-cycle strobes qualified by an address hit; loads complete
// combinationally in the same cycle, stores commit at the rising edge, and
// a simultaneous load sees the pre-store value.
module bus_peripheral
  import bus_peripheral_pkg::*;
#(
  parameter logic [31:0] BASE = 32'h4000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] Address,
  input  logic [31:0] Write_data,
  input  logic        MemRead,
  input  logic        MemWrite,
  output logic [31:0] Read_data,
  output logic [7:0]  leds,
  output logic [11:0] digits,
  output logic        irqout
);

  logic [7:0]  led_q, led_d;
  logic [11:0] digi_q, digi_d;
  logic [31:0] systick_q, systick_d;

  logic        hit;
  logic        wr;
  logic [4:0]  ofs;
  logic [31:0] th, tl;
  logic [2:0]  tcon;
  logic        unused_addr_bits;

  // Word-aligned decode; the two byte-lane bits carry no meaning here.
  assign unused_addr_bits = ^Address[1:0];
  assign ofs = {Address[4:2], 2'b00};
  assign hit = (Address[31:5] == BASE[31:5]) && (Address[4:2] <= LAST_WORD);
  assign wr  = MemWrite && hit;

  periph_timer u_timer (
    .clk     (clk),
    .reset   (reset),
    .th_we   (wr && (ofs == OFS_TH)),
    .tl_we   (wr && (ofs == OFS_TL)),
    .tcon_we (wr && (ofs == OFS_TCON)),
    .wdata   (Write_data),
    .th      (th),
    .tl      (tl),
    .tcon    (tcon),
    .irqout  (irqout)
  );

  // Next-state for LED/DIGI stores and the always-running SYSTICK.
  always_comb begin
    led_d     = led_q;
    digi_d    = digi_q;
    systick_d = systick_q + 32'd1;
    if (wr && (ofs == OFS_LED))  led_d  = Write_data[7:0];
    if (wr && (ofs == OFS_DIGI)) digi_d = Write_data[11:0];
  end

  // Register update with synchronous reset taking priority.
  always_ff @(posedge clk) begin
    if (reset) begin
      led_q     <= '0;
      digi_q    <= '0;
      systick_q <= '0;
    end else begin
      led_q     <= led_d;
      digi_q    <= digi_d;
      systick_q <= systick_d;
    end
  end

  // Load mux: zero unless a read strobe hits an implemented register.
  always_comb begin
    Read_data = 32'h0;
    if (MemRead && hit) begin
      case (ofs)
        OFS_TH:      Read_data = th;
        OFS_TL:      Read_data = tl;
        OFS_TCON:    Read_data = {29'h0, tcon};
        OFS_LED:     Read_data = {24'h0, led_q};
        OFS_DIGI:    Read_data = {20'h0, digi_q};
        OFS_SYSTICK: Read_data = systick_q;
        default:     Read_data = 32'h0;
      endcase
    end
  end

  assign leds   = led_q;
  assign digits = digi_q;

endmodule

// File: tb/tb_bus_peripheral.sv
// Self-checking bench for bus_peripheral: directed scenarios followed by a
// randomized bus traffic phase, all compared against a behavioural model.
`timescale 1ns/1ps
module tb_bus_peripheral;

  localparam logic [31:0] BASE = 32'h4000_0000;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #10 clk = ~clk;

  logic [31:0] Address, Write_data, Read_data;
  logic        MemRead, MemWrite;
  logic [7:0]  leds;
  logic [11:0] digits;
  logic        irqout;

  bus_peripheral #(.BASE(BASE)) dut (
    .clk        (clk),
    .reset      (reset),
    .Address    (Address),
    .Write_data (Write_data),
    .MemRead    (MemRead),
    .MemWrite   (MemWrite),
    .Read_data  (Read_data),
    .leds       (leds),
    .digits     (digits),
    .irqout     (irqout)
  );

  // ---------------- behavioural model ----------------
  logic [31:0] m_th, m_tl, m_sys;
  logic [2:0]  m_tcon;
  logic [7:0]  m_led;
  logic [11:0] m_digi;

  int checks   = 0;
  int failures = 0;

  function automatic bit in_page(input logic [31:0] a);
    int word;
    word = (a - BASE) / 4;
    return (a >= BASE) && (a < BASE + 32'd32) && (word <= 5);
  endfunction

  function automatic logic [31:0] model_read(input logic [31:0] a, input logic re);
    if (!re || !in_page(a)) return 32'h0;
    case ((a - BASE) / 4)
      0: return m_th;
      1: return m_tl;
      2: return 32'(m_tcon);
      3: return 32'(m_led);
      4: return 32'(m_digi);
      default: return m_sys;
    endcase
  endfunction

  // One clock of the model, using the inputs currently presented to the DUT.
  task automatic model_step();
    logic [31:0] n_tl;
    logic [2:0]  n_tcon;
    bit          ovf;
    int          word;
    if (reset) begin
      m_th = 0; m_tl = 0; m_tcon = 0; m_led = 0; m_digi = 0; m_sys = 0;
      return;
    end
    ovf    = m_tcon[0] && (m_tl == 32'hFFFF_FFFF);
    n_tl   = !m_tcon[0] ? m_tl : (ovf ? m_th : m_tl + 1);
    n_tcon = m_tcon;
    if (ovf && m_tcon[1]) n_tcon[2] = 1'b1;
    if (MemWrite && in_page(Address)) begin
      word = (Address - BASE) / 4;
      case (word)
        0: m_th = Write_data;
        1: n_tl = Write_data;
        2: n_tcon = {Write_data[2] | (Write_data[1] & ovf), Write_data[1:0]};
        3: m_led = Write_data[7:0];
        4: m_digi = Write_data[11:0];
        default: ;
      endcase
    end
    m_tl   = n_tl;
    m_tcon = n_tcon;
    m_sys  = m_sys + 1;
  endtask

  // ---------------- scoreboard ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  task automatic check_outs(input string tag);
    check({tag, "_irq"},    32'(irqout), 32'(m_tcon[1] & m_tcon[2]));
    check({tag, "_leds"},   32'(leds),   32'(m_led));
    check({tag, "_digits"}, 32'(digits), 32'(m_digi));
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    MemRead = 0; MemWrite = 0; Address = 32'h0; Write_data = 32'h0;
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    MemWrite = 1; MemRead = 0; Address = a; Write_data = d;
    tick();
    idle();
  endtask

  // Combinational read inside the current cycle, compared with the model.
  task automatic read_chk(input logic [31:0] a, input string tag);
    MemRead = 1; MemWrite = 0; Address = a;
    #1;
    check(tag, Read_data, model_read(a, 1'b1));
    MemRead = 0;
  endtask

  // ---------------- stimulus ----------------
  logic [31:0] st1, st2;
  int          sel;

  initial begin
    idle();
    reset = 1;
    tick();
    tick();

    // Reset state: every offset and the holes read zero.
    for (int i = 0; i < 8; i++) read_chk(BASE + 32'(i * 4), $sformatf("rst_rd%0d", i));
    read_chk(32'h1000_0000, "rst_outside");
    MemRead = 1; Address = BASE + 32'h18; #1;
    check("rst_hole18", Read_data, 32'h0);
    MemRead = 0;
    check_outs("rst");
    check("rst_irq_const", 32'(irqout), 32'h0);
    reset = 0;
    tick();

    // Timer reload and interrupt.
    bus_write(BASE + 32'h00, 32'hFFFF_FFFC);
    bus_write(BASE + 32'h04, 32'hFFFF_FFFE);
    bus_write(BASE + 32'h08, 32'h3);
    read_chk(BASE + 32'h04, "tl_step0");
    check("tl_step0_c", Read_data, 32'hFFFF_FFFE);
    tick();
    read_chk(BASE + 32'h04, "tl_step1");
    check("tl_step1_c", Read_data, 32'hFFFF_FFFF);
    check("irq_pre_reload", 32'(irqout), 32'h0);
    tick();
    read_chk(BASE + 32'h04, "tl_reload");
    check("tl_reload_c", Read_data, 32'hFFFF_FFFC);
    read_chk(BASE + 32'h08, "tcon_after_reload");
    check("tcon7_c", Read_data, 32'h7);
    check("irq_after_reload", 32'(irqout), 32'h1);

    // Clear status with irq high, then the next reload raises it again.
    bus_write(BASE + 32'h08, 32'h3);
    check("irq_cleared", 32'(irqout), 32'h0);
    for (int i = 0; i < 3; i++) begin
      check_outs($sformatf("rearm%0d", i));
      tick();
    end
    check("irq_rearmed", 32'(irqout), 32'h1);
    check_outs("rearm_done");

    // Clear exactly on the overflow cycle: status must survive.
    bus_write(BASE + 32'h08, 32'h3);
    tick();
    tick();
    read_chk(BASE + 32'h04, "tl_at_ovf");
    bus_write(BASE + 32'h08, 32'h3);
    read_chk(BASE + 32'h08, "tcon_clear_on_ovf");
    check("tcon_clear_on_ovf_c", Read_data, 32'h7);
    check("irq_clear_on_ovf", 32'(irqout), 32'h1);

    // LED and DIGI.
    bus_write(BASE + 32'h0C, 32'hFFFF_FFA5);
    bus_write(BASE + 32'h10, 32'hFFFF_FE3F);
    check("leds_c", 32'(leds), 32'hA5);
    check("digits_c", 32'(digits), 32'hE3F);
    read_chk(BASE + 32'h0C, "led_rd");
    check("led_rd_c", Read_data, 32'h0000_00A5);
    read_chk(BASE + 32'h10, "digi_rd");
    check("digi_rd_c", Read_data, 32'h0000_0E3F);

    // SYSTICK spacing and write-ignore.
    read_chk(BASE + 32'h14, "systick_t0");
    st1 = Read_data;
    repeat (10) tick();
    MemRead = 1; Address = BASE + 32'h14; #1;
    st2 = Read_data;
    MemRead = 0;
    check("systick_diff", st2 - st1, 32'd10);
    bus_write(BASE + 32'h14, 32'h5);
    read_chk(BASE + 32'h14, "systick_after_wr");

    // Reset while the timer is about to overflow.
    bus_write(BASE + 32'h00, 32'h1234_5678);
    bus_write(BASE + 32'h04, 32'hFFFF_FFFD);
    bus_write(BASE + 32'h08, 32'h3);
    reset = 1;
    tick();
    reset = 0;
    for (int i = 0; i < 6; i++) read_chk(BASE + 32'(i * 4), $sformatf("midrst_rd%0d", i));
    check_outs("midrst");
    for (int i = 0; i < 4; i++) begin
      tick();
      check("midrst_no_irq", 32'(irqout), 32'h0);
    end

    // Randomized traffic.
    for (int n = 0; n < 400; n++) begin
      sel = $urandom_range(0, 9);
      if (sel < 8)       Address = BASE + 32'(sel * 4);
      else if (sel == 8) Address = 32'h1000_0000 + 32'($urandom_range(0, 7) * 4);
      else               Address = BASE + 32'h20;
      Address[1:0] = 2'($urandom_range(0, 3));
      MemRead  = 1'($urandom_range(0, 1));
      MemWrite = ($urandom_range(0, 3) == 0);
      case (sel)
        0: Write_data = $urandom_range(0, 1) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;
        1: Write_data = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
        2: Write_data = 32'($urandom_range(0, 7));
        default: Write_data = $urandom;
      endcase
      reset = ($urandom_range(0, 60) == 0);
      #1;
      check("rnd_rd", Read_data, model_read(Address, MemRead));
      check_outs("rnd");
      tick();
    end
    reset = 0;
    idle();
    tick();
    check_outs("final");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
